// File: rtl/mul4_vector_evaluator.sv
// Fitness evaluator for 16-lane bit-sliced 2x2 multiplier candidates: drives an exhaustive
// vector then LFSR vectors, and counts candidate output bits that agree with a golden multiplier.
module mul4_vector_evaluator #(
  parameter int          NUM_VECTORS = 16,
  parameter int          DUT_LATENCY = 0,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          SCORE_W     = $clog2(64*NUM_VECTORS+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic               perfect,
  output logic [15:0]        a1,
  output logic [15:0]        a0,
  output logic [15:0]        b1,
  output logic [15:0]        b0,
  input  logic [15:0]        y3,
  input  logic [15:0]        y2,
  input  logic [15:0]        y1,
  input  logic [15:0]        y0,
  output logic [1:0]         state
);

  // Control: start is a request sampled only in IDLE; busy covers every cycle a vector is
  // applied; done pulses for one cycle in DONE, when score and perfect become final.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [15:0]        SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam int                 VEC_W     = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int                 WAIT_W    = (DUT_LATENCY > 0) ? $clog2(DUT_LATENCY+1) : 1;
  localparam logic [VEC_W-1:0]   LAST_VEC  = VEC_W'(NUM_VECTORS-1);
  localparam logic [WAIT_W-1:0]  LAST_WAIT = WAIT_W'(DUT_LATENCY);
  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(64*NUM_VECTORS);

  state_t             st;
  logic [15:0]        lfsr;
  logic [VEC_W-1:0]   vec_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [15:0]        g0, g1, g2, g3;
  logic [6:0]         vec_sum;
  logic [SCORE_W-1:0] score_next;
  logic [15:0]        lfsr_next;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

  assign state = st;

  // Golden products are taken from the registered stimulus, so they match what the candidate saw.
  assign g0 = a0 & b0;
  assign g1 = (a1 & b0) ^ (a0 & b1);
  assign g2 = (a1 & b1) & ~(a0 & b0);
  assign g3 = a1 & a0 & b1 & b0;

  assign vec_sum = {2'b0, popcount16(~(y0 ^ g0))} + {2'b0, popcount16(~(y1 ^ g1))}
                 + {2'b0, popcount16(~(y2 ^ g2))} + {2'b0, popcount16(~(y3 ^ g3))};
  assign score_next = score + SCORE_W'(vec_sum);
  assign lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      score    <= '0;
      perfect  <= 1'b0;
      a1       <= '0;
      a0       <= '0;
      b1       <= '0;
      b0       <= '0;
      lfsr     <= SEED_EFF;
      vec_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            st       <= RUN;
            busy     <= 1'b1;
            score    <= '0;
            perfect  <= 1'b0;
            lfsr     <= SEED_EFF;
            vec_cnt  <= '0;
            wait_cnt <= '0;
            // Exhaustive vector: lane i carries operand combination i.
            a0       <= 16'hAAAA;
            a1       <= 16'hCCCC;
            b0       <= 16'hF0F0;
            b1       <= 16'hFF00;
          end
        end
        RUN: begin
          if (wait_cnt != LAST_WAIT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end else begin
            wait_cnt <= '0;
            score    <= score_next;
            if (vec_cnt == LAST_VEC) begin
              st      <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              perfect <= (score_next == MAX_SCORE);
              a1      <= '0;
              a0      <= '0;
              b1      <= '0;
              b0      <= '0;
            end else begin
              vec_cnt <= vec_cnt + VEC_W'(1);
              a0      <= lfsr;
              a1      <= {lfsr[11:0], lfsr[15:12]};
              b0      <= {lfsr[7:0], lfsr[15:8]};
              b1      <= {lfsr[3:0], lfsr[15:4]};
              lfsr    <= lfsr_next;
            end
          end
        end
        DONE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul4_vector_evaluator.sv
// Directed bench for mul4_vector_evaluator: three instances (default, short pipelined, zero seed)
// driven by behavioural candidate models; scores are checked against hand-computed values.
module tb_mul4_vector_evaluator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [1:0] mode0 = '0;
  logic [1:0] mode1 = '0;

  logic        busy0, done0, perfect0, busy1, done1, perfect1, busy2, done2, perfect2;
  logic [10:0] score0, score2;
  logic [6:0]  score1;
  logic [1:0]  state0, state1, state2;
  logic [15:0] a1_0, a0_0, b1_0, b0_0, a1_1, a0_1, b1_1, b0_1, a1_2, a0_2, b1_2, b0_2;
  logic [63:0] y_0, y_1, y_2;
  logic [63:0] stim0, stim1, stim2;
  logic [63:0] d1 = '0, d2 = '0, d3 = '0;

  int checks   = 0;
  int failures = 0;
  logic [10:0] exp_q[$];
  logic [63:0] log0[$];
  logic [63:0] log2[$];

  wire [2:0] busy_v = {busy2, busy1, busy0};
  wire [2:0] done_v = {done2, done1, done0};

  assign stim0 = {a1_0, a0_0, b1_0, b0_0};
  assign stim1 = {a1_1, a0_1, b1_1, b0_1};
  assign stim2 = {a1_2, a0_2, b1_2, b0_2};

  mul4_vector_evaluator u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy0), .done(done0), .score(score0),
    .perfect(perfect0), .a1(a1_0), .a0(a0_0), .b1(b1_0), .b0(b0_0),
    .y3(y_0[63:48]), .y2(y_0[47:32]), .y1(y_0[31:16]), .y0(y_0[15:0]), .state(state0));

  mul4_vector_evaluator #(.NUM_VECTORS(1), .DUT_LATENCY(2)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy1), .done(done1), .score(score1),
    .perfect(perfect1), .a1(a1_1), .a0(a0_1), .b1(b1_1), .b0(b0_1),
    .y3(y_1[63:48]), .y2(y_1[47:32]), .y1(y_1[31:16]), .y0(y_1[15:0]), .state(state1));

  mul4_vector_evaluator #(.SEED(16'h0000)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy2), .done(done2), .score(score2),
    .perfect(perfect2), .a1(a1_2), .a0(a0_2), .b1(b1_2), .b0(b0_2),
    .y3(y_2[63:48]), .y2(y_2[47:32]), .y1(y_2[31:16]), .y0(y_2[15:0]), .state(state2));

  // Candidate models: a 2x2 multiplier written from the product truth table.
  function automatic logic [63:0] golden(input logic [63:0] s);
    logic [15:0] a1, a0, b1, b0;
    logic [15:0] p0, p1, p2, p3;
    {a1, a0, b1, b0} = s;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] p;
      p = {2'b0, a1[i], a0[i]} * {2'b0, b1[i], b0[i]};
      {p3[i], p2[i], p1[i], p0[i]} = p;
    end
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always_comb begin
    y_0 = golden(stim0);
    if (mode0 == 2'd1) y_0[63:48] = ~y_0[63:48];
    y_2 = golden(stim2);
    case (mode1)
      2'd0:    y_1 = golden(d2);
      2'd1:    y_1 = golden(d3);
      default: y_1 = '0;
    endcase
  end

  always @(posedge clk) begin
    d1 <= stim1;
    d2 <= d1;
    d3 <= d2;
  end

  // Clock and reset.
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy0) log0.push_back(stim0);
    if (busy2) log2.push_back(stim2);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] score_of(input int u);
    case (u)
      0:       return score0;
      1:       return {4'b0, score1};
      default: return score2;
    endcase
  endfunction

  function automatic logic perfect_of(input int u);
    case (u)
      0:       return perfect0;
      1:       return perfect1;
      default: return perfect2;
    endcase
  endfunction

  function automatic logic [63:0] stim_of(input int u);
    case (u)
      0:       return stim0;
      1:       return stim1;
      default: return stim2;
    endcase
  endfunction

  // Driver: one evaluation on unit u; the expected score comes from the scoreboard queue.
  task automatic run_eval(input int u, input string tag, input logic exp_perf, input int exp_edges);
    logic [10:0] exp_s;
    int k, busy_n;
    bit seen;
    exp_s = exp_q.pop_front();
    if (u == 0) log0.delete();
    if (u == 2) log2.delete();
    @(negedge clk); start_v[u] = 1'b1;
    @(negedge clk); start_v[u] = 1'b0;
    k = 0; busy_n = 0; seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_v[u]) begin
        seen = 1;
        break;
      end
      if (busy_v[u]) busy_n++;
      @(negedge clk); k++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_done_edge"}, 64'(k), 64'(exp_edges));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_edges));
    check({tag, "_busy_at_done"}, 64'(busy_v[u]), 64'd0);
    check({tag, "_score"}, 64'(score_of(u)), 64'(exp_s));
    check({tag, "_perfect"}, 64'(perfect_of(u)), 64'(exp_perf));
    check({tag, "_stim_idle"}, stim_of(u), 64'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done_v[u]), 64'd0);
  endtask

  task automatic check_vectors(input int u, input logic [15:0] seed);
    logic [63:0] q[$];
    logic [63:0] exp_v;
    logic [15:0] l;
    if (u == 0) q = log0; else q = log2;
    check($sformatf("u%0d_vec_count", u), 64'(q.size()), 64'd16);
    l = seed;
    for (int v = 0; v < 16 && v < q.size(); v++) begin
      if (v == 0) begin
        exp_v = {16'hCCCC, 16'hAAAA, 16'hFF00, 16'hF0F0};
      end else begin
        exp_v = {rotl(l, 4), l, rotl(l, 12), rotl(l, 8)};
        l = lfsr_step(l);
      end
      check($sformatf("u%0d_vec%0d", u, v), q[v], exp_v);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_score", 64'(score0), 64'd0);
    check("rst_perfect", 64'(perfect0), 64'd0);
    check("rst_stim", stim0, 64'd0);
    check("rst_state", 64'(state0), 64'd0);

    exp_q.push_back(11'd1024);
    run_eval(0, "golden16", 1'b1, 16);
    check_vectors(0, 16'hACE1);

    mode1 = 2'd2; exp_q.push_back(11'd50);
    run_eval(1, "zeros1", 1'b0, 3);
    mode1 = 2'd0; exp_q.push_back(11'd64);
    run_eval(1, "lat2_match", 1'b1, 3);
    mode1 = 2'd1; exp_q.push_back(11'd50);
    run_eval(1, "lat2_slow", 1'b0, 3);

    mode0 = 2'd1; exp_q.push_back(11'd768);
    run_eval(0, "y3_inverted", 1'b0, 16);
    mode0 = 2'd0;

    exp_q.push_back(11'd1024);
    run_eval(2, "seed0", 1'b1, 16);
    check_vectors(2, 16'hACE1);

    // Reset in the middle of a run.
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy0), 64'd0);
    check("midrst_done", 64'(done0), 64'd0);
    check("midrst_score", 64'(score0), 64'd0);
    check("midrst_perfect", 64'(perfect0), 64'd0);
    check("midrst_stim", stim0, 64'd0);
    check("midrst_state", 64'(state0), 64'd0);
    @(negedge clk); rst = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (done0 || busy0) n++;
    end
    check("midrst_no_done", 64'(n), 64'd0);
    exp_q.push_back(11'd1024);
    run_eval(0, "after_rst", 1'b1, 16);

    // Start pulses during busy and during the done cycle are ignored.
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    n = 0;
    while (!done0 && n < 300) begin
      @(negedge clk); n++;
    end
    check("ign_done_seen", 64'(done0), 64'd1);
    check("ign_state_done", 64'(state0), 64'd2);
    start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    n = 0;
    repeat (40) begin
      if (done0 || busy0) n++;
      @(negedge clk);
    end
    check("ign_no_restart", 64'(n), 64'd0);
    check("ign_score", 64'(score0), 64'd1024);
    check("ign_perfect", 64'(perfect0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
